// File: rtl/memory_cycle_lsu.sv
// Memory stage of a 5-stage RISC-V pipeline with a variable-latency data bus.
// It issues loads and stores on a req/ready bus, stalls the upstream stages
// while an access is outstanding, and registers the M->W pipeline fields.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   RegWriteM..PCPlus4M   E->M pipeline register outputs (held stable while StallM=1)
//   mem_ready, mem_rdata  responder completion strobe and load data
//   mem_req, mem_we       bus request and write select
//   mem_addr, mem_wdata   bus byte address and store data
//   StallM                freeze PC and the F/D, D/E and E/M registers
//   RegWriteW..PCPlus4W   M->W pipeline register
//   ErrorW                one-cycle pulse on a misaligned access or a bus timeout
module memory_cycle_lsu #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              ResultSrcM,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [4:0]        RdM,
    input  logic [31:0]       PCPlus4M,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RdW,
    output logic [31:0]       ALUResultW,
    output logic [31:0]       ReadDataW,
    output logic [31:0]       PCPlus4W,
    output logic              ErrorW
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              regwrite_q, regwrite_d;
    logic              resultsrc_q, resultsrc_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       aluresult_q, aluresult_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [31:0]       pcplus4_q, pcplus4_d;
    logic              error_q, error_d;

    logic              mem_op, misaligned;
    logic              req, stall, load_w;

    assign mem_op     = ResultSrcM | MemWriteM;
    assign misaligned = mem_op & (ALUResultM[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req         = 1'b0;
        stall       = 1'b0;
        load_w      = 1'b0;
        error_d     = 1'b0;
        mem_we      = MemWriteM;
        mem_addr    = ALUResultM[ADDR_W-1:0];
        mem_wdata   = WriteDataM;

        case (state_q)
            StIdle: begin
                if (!mem_op) begin
                    load_w = 1'b1;
                end else if (misaligned) begin
                    error_d = 1'b1;
                end else begin
                    req = 1'b1;
                    if (mem_ready) begin
                        load_w = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = ALUResultM[ADDR_W-1:0];
                        wdata_d = WriteDataM;
                        cnt_d   = 8'd1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                req       = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ready) begin
                    load_w  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = StIdle;
                end else if (cnt_q == TimeoutCnt) begin
                    // Abort: release the pipeline this cycle and drop the instruction.
                    error_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // W bubble unless an instruction retires at this edge.
        regwrite_d  = 1'b0;
        resultsrc_d = 1'b0;
        rd_d        = 5'd0;
        aluresult_d = 32'd0;
        readdata_d  = 32'd0;
        pcplus4_d   = 32'd0;
        if (load_w) begin
            regwrite_d  = RegWriteM;
            resultsrc_d = ResultSrcM;
            rd_d        = RdM;
            aluresult_d = ALUResultM;
            readdata_d  = ResultSrcM ? mem_rdata : 32'd0;
            pcplus4_d   = PCPlus4M;
        end
    end

    // Gated by rst so the bus and the stall drop asynchronously on reset.
    assign mem_req = req & rst;
    assign StallM  = stall & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= 5'd0;
            aluresult_q <= 32'd0;
            readdata_q  <= 32'd0;
            pcplus4_q   <= 32'd0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            pcplus4_q   <= pcplus4_d;
            error_q     <= error_d;
        end
    end

    assign RegWriteW  = regwrite_q;
    assign ResultSrcW = resultsrc_q;
    assign RdW        = rd_q;
    assign ALUResultW = aluresult_q;
    assign ReadDataW  = readdata_q;
    assign PCPlus4W   = pcplus4_q;
    assign ErrorW     = error_q;

endmodule
